// File: rtl/sum_tree_pkg.sv
// Shared types and elaboration helpers for the pipelined multi-operand adder.
package sum_tree_pkg;

  localparam int EXT_MAX_W = 128;

  typedef struct packed {
    logic acc;
    logic clr;
    logic valid;
  } beat_ctrl_t;

  function automatic int sum_levels(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Number of partial sums left after lvl pairwise reductions of n operands.
  function automatic int level_count(input int n, input int lvl);
    return (n + (1 << lvl) - 1) >> lvl;
  endfunction

  function automatic logic [EXT_MAX_W-1:0] ext_operand(input logic [EXT_MAX_W-1:0] op,
                                                       input int in_w,
                                                       input bit is_signed);
    logic [EXT_MAX_W-1:0] res;
    logic fill;
    res  = '0;
    fill = 1'b0;
    for (int i = 0; i < EXT_MAX_W; i++) begin
      if (i == in_w - 1) fill = is_signed & op[i];
    end
    for (int i = 0; i < EXT_MAX_W; i++) begin
      res[i] = (i < in_w) ? op[i] : fill;
    end
    return res;
  endfunction

endpackage

// File: rtl/sum_tree_level.sv
// One registered pairwise-reduction level; an odd leftover operand is carried through unchanged.
module sum_tree_level
  import sum_tree_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int W    = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  beat_ctrl_t                      ctrl_in,
  input  logic [N_IN*W-1:0]               data_in,
  output beat_ctrl_t                      ctrl_out,
  output logic [((N_IN+1)/2)*W-1:0]       data_out
);

  localparam int N_OUT = (N_IN + 1) / 2;

  logic [N_OUT*W-1:0] sums;

  for (genvar j = 0; j < N_OUT; j++) begin : g_pair
    if (2 * j + 1 < N_IN) begin : g_add
      assign sums[j*W +: W] = data_in[2*j*W +: W] + data_in[(2*j+1)*W +: W];
    end else begin : g_pass
      assign sums[j*W +: W] = data_in[2*j*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_out <= '0;
      data_out <= '0;
    end else if (en) begin
      ctrl_out <= ctrl_in;
      data_out <= sums;
    end
  end

endmodule

// File: rtl/pipelined_sum_tree.sv
// Pipelined multi-operand adder: registered binary reduction tree followed by an
// output stage that either passes the tree sum or accumulates it with overflow reporting.
module pipelined_sum_tree
  import sum_tree_pkg::*;
#(
  parameter int NUM_OPS = 5,
  parameter int IN_W    = 32,
  parameter int OUT_W   = 64,
  parameter int SIGNED  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_OPS*IN_W-1:0] in_data,
  input  logic                    in_acc,
  input  logic                    in_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_ovf
);

  localparam int LEVELS = sum_levels(NUM_OPS);

  if (OUT_W < IN_W + $clog2(NUM_OPS) || OUT_W > EXT_MAX_W || IN_W > EXT_MAX_W) begin : g_width_check
    $error("pipelined_sum_tree: OUT_W too narrow for NUM_OPS operands of IN_W bits");
  end

  logic                      stall;
  logic                      en;
  beat_ctrl_t                in_ctrl;
  logic [NUM_OPS*OUT_W-1:0]  ext_data;
  logic [OUT_W-1:0]          tree_sum;
  beat_ctrl_t                tree_ctrl;
  logic [OUT_W:0]            acc_full;
  logic                      acc_ovf;

  // Every register in the block freezes together while the output beat is held.
  assign stall    = out_valid & ~out_ready;
  assign en       = ~stall;
  assign in_ready = rst | ~stall;
  assign in_ctrl  = '{acc: in_acc, clr: in_clr, valid: in_valid};

  for (genvar k = 0; k < NUM_OPS; k++) begin : g_ext
    assign ext_data[k*OUT_W +: OUT_W] =
      OUT_W'(ext_operand(EXT_MAX_W'(in_data[k*IN_W +: IN_W]), IN_W, SIGNED != 0));
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int N_IN  = level_count(NUM_OPS, l);
    localparam int N_OUT = level_count(NUM_OPS, l + 1);

    logic [N_IN*OUT_W-1:0]  d_in;
    logic [N_OUT*OUT_W-1:0] d_out;
    beat_ctrl_t             c_in;
    beat_ctrl_t             c_out;

    if (l == 0) begin : g_first
      assign d_in = ext_data;
      assign c_in = in_ctrl;
    end else begin : g_next
      assign d_in = g_lvl[l-1].d_out;
      assign c_in = g_lvl[l-1].c_out;
    end

    sum_tree_level #(
      .N_IN (N_IN),
      .W    (OUT_W)
    ) u_level (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .ctrl_in  (c_in),
      .data_in  (d_in),
      .ctrl_out (c_out),
      .data_out (d_out)
    );
  end

  assign tree_sum  = g_lvl[LEVELS-1].d_out;
  assign tree_ctrl = g_lvl[LEVELS-1].c_out;

  assign acc_full = {1'b0, out_data} + {1'b0, tree_sum};
  assign acc_ovf  = (SIGNED != 0)
                  ? ((out_data[OUT_W-1] == tree_sum[OUT_W-1]) &&
                     (acc_full[OUT_W-1] != out_data[OUT_W-1]))
                  : acc_full[OUT_W];

  // out_data doubles as the accumulator, so bubbles leave it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (en) begin
      out_valid <= tree_ctrl.valid;
      if (tree_ctrl.valid) begin
        if (tree_ctrl.clr || !tree_ctrl.acc) begin
          out_data <= tree_sum;
          out_ovf  <= 1'b0;
        end else begin
          out_data <= acc_full[OUT_W-1:0];
          out_ovf  <= acc_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_sum_tree.sv
// Directed bench for pipelined_sum_tree: default, 35-bit unsigned and 35-bit signed instances share stimulus.
module tb_pipelined_sum_tree;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [159:0] in_data;
  logic         in_acc;
  logic         in_clr;
  logic         out_ready;

  logic         ir64, ir35, irs;
  logic         ov64, ov35, ovs;
  logic [63:0]  d64;
  logic [34:0]  d35, ds;
  logic         f64, f35, fs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [159:0] ops;
    bit           acc;
    bit           clr;
    logic [63:0]  exp_data;
    bit           exp_ovf;
  } vec_t;

  vec_t         vecs[8];
  logic [159:0] q_ops[8];
  bit           q_acc[8];
  bit           q_clr[8];
  logic [63:0]  r_data[3][16];
  bit           r_ovf[3][16];
  int           r_cyc[3][16];
  int           r_n[3];

  always #5 clk = ~clk;

  pipelined_sum_tree dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir64), .in_data(in_data),
    .in_acc(in_acc), .in_clr(in_clr), .out_valid(ov64), .out_ready(out_ready),
    .out_data(d64), .out_ovf(f64)
  );

  pipelined_sum_tree #(.OUT_W(35), .SIGNED(0)) dut35 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir35), .in_data(in_data),
    .in_acc(in_acc), .in_clr(in_clr), .out_valid(ov35), .out_ready(out_ready),
    .out_data(d35), .out_ovf(f35)
  );

  pipelined_sum_tree #(.OUT_W(35), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irs), .in_data(in_data),
    .in_acc(in_acc), .in_clr(in_clr), .out_valid(ovs), .out_ready(out_ready),
    .out_data(ds), .out_ovf(fs)
  );

  function automatic logic [159:0] ops5(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d,
                                        input logic [31:0] e);
    return {e, d, c, b, a};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [159:0] ops, input bit acc, input bit clr, input bit valid);
    in_data  = ops;
    in_acc   = acc;
    in_clr   = clr;
    in_valid = valid;
  endtask

  // Streams q_* beats back-to-back and records every result of all three instances.
  task automatic runSeq(input int n);
    for (int d = 0; d < 3; d++) r_n[d] = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < n + 12; cyc++) begin
      @(negedge clk);
      if (cyc < n) applyStimulus(q_ops[cyc], q_acc[cyc], q_clr[cyc], 1'b1);
      else         applyStimulus('0, 1'b0, 1'b0, 1'b0);
      #1;
      if (ov64 && r_n[0] < 16) begin
        r_data[0][r_n[0]] = d64; r_ovf[0][r_n[0]] = f64; r_cyc[0][r_n[0]] = cyc; r_n[0]++;
      end
      if (ov35 && r_n[1] < 16) begin
        r_data[1][r_n[1]] = 64'(d35); r_ovf[1][r_n[1]] = f35; r_cyc[1][r_n[1]] = cyc; r_n[1]++;
      end
      if (ovs && r_n[2] < 16) begin
        r_data[2][r_n[2]] = 64'(ds); r_ovf[2][r_n[2]] = fs; r_cyc[2][r_n[2]] = cyc; r_n[2]++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sent;
    int got;
    bit holding;
    bit any_valid;
    logic [63:0] held;

    vecs[0] = '{ops5(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF),
                0, 0, 64'h4_FFFF_FFFB, 0};
    vecs[1] = '{ops5(1, 2, 3, 4, 5), 0, 1, 64'd15, 0};
    vecs[2] = '{ops5(1, 2, 3, 4, 5), 1, 0, 64'd30, 0};
    vecs[3] = '{ops5(10, 20, 30, 40, 50), 0, 0, 64'd150, 0};
    vecs[4] = '{ops5(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000),
                0, 1, 64'h2_8000_0000, 0};
    vecs[5] = '{ops5(32'hFFFF_FFFF, 0, 0, 0, 0), 1, 0, 64'h3_7FFF_FFFF, 0};
    vecs[6] = '{ops5(0, 0, 0, 0, 0), 1, 0, 64'h3_7FFF_FFFF, 0};
    vecs[7] = '{ops5(7, 0, 0, 0, 1), 1, 1, 64'd8, 0};

    rst       = 1'b1;
    out_ready = 1'b1;
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_out_valid", 64'(ov64), 0);
    checkOutput("reset_out_data", d64, 0);
    checkOutput("reset_out_ovf", 64'(f64), 0);
    checkOutput("reset_in_ready", 64'(ir64), 1);

    // Table vectors streamed back-to-back on the default instance.
    for (int k = 0; k < 8; k++) begin
      q_ops[k] = vecs[k].ops; q_acc[k] = vecs[k].acc; q_clr[k] = vecs[k].clr;
    end
    runSeq(8);
    checkOutput("tbl_count", 64'(r_n[0]), 8);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("tbl%0d_data", k), r_data[0][k], vecs[k].exp_data);
      checkOutput($sformatf("tbl%0d_ovf", k), 64'(r_ovf[0][k]), 64'(vecs[k].exp_ovf));
      checkOutput($sformatf("tbl%0d_latency", k), 64'(r_cyc[0][k] - k), 4);
    end

    // Clear then three accumulates back-to-back: 15, 30, 45, 60 on consecutive cycles.
    q_ops[0] = ops5(1, 2, 3, 4, 5); q_acc[0] = 0; q_clr[0] = 1;
    for (int k = 1; k < 4; k++) begin
      q_ops[k] = ops5(1, 2, 3, 4, 5); q_acc[k] = 1; q_clr[k] = 0;
    end
    runSeq(4);
    checkOutput("acc_count", 64'(r_n[0]), 4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("acc%0d_data", k), r_data[0][k], 64'(15 * (k + 1)));
      checkOutput($sformatf("acc%0d_cycle", k), 64'(r_cyc[0][k] - r_cyc[0][0]), 64'(k));
    end

    // Eight beats with a five-cycle downstream stall in the middle.
    sent = 0; got = 0; holding = 0; held = '0;
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 6 && cyc < 11);
      if (sent < 8) applyStimulus(ops5(sent, sent, sent, sent, sent + 1), 1'b0, 1'b0, 1'b1);
      else          applyStimulus('0, 1'b0, 1'b0, 1'b0);
      #1;
      if (ov64 && !out_ready) begin
        checkOutput("stall_in_ready", 64'(ir64), 0);
        if (holding) checkOutput("stall_hold", d64, held);
        held = d64; holding = 1;
      end else begin
        holding = 0;
      end
      if (ov64 && out_ready) begin
        checkOutput($sformatf("stream%0d_data", got), d64, 64'(5 * got + 1));
        got++;
      end
      if (in_valid && ir64) sent++;
    end
    checkOutput("stream_count", 64'(got), 8);
    @(negedge clk);
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1;
    checkOutput("stream_no_dup", 64'(ov64), 0);
    repeat (4) @(negedge clk);

    // 35-bit unsigned: clear, accumulate with carry out, then a non-sticky pass beat.
    q_ops[0] = ops5(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    q_acc[0] = 0; q_clr[0] = 1;
    q_ops[1] = q_ops[0]; q_acc[1] = 1; q_clr[1] = 0;
    q_ops[2] = ops5(1, 2, 3, 4, 5); q_acc[2] = 0; q_clr[2] = 0;
    runSeq(3);
    checkOutput("u35_count", 64'(r_n[1]), 3);
    checkOutput("u35_clr_data", r_data[1][0], 64'h4_FFFF_FFFB);
    checkOutput("u35_clr_ovf", 64'(r_ovf[1][0]), 0);
    checkOutput("u35_acc_data", r_data[1][1], 64'h1_FFFF_FFF6);
    checkOutput("u35_acc_ovf", 64'(r_ovf[1][1]), 1);
    checkOutput("u35_pass_data", r_data[1][2], 64'd15);
    checkOutput("u35_pass_ovf", 64'(r_ovf[1][2]), 0);

    // 35-bit signed: mixed signs cancel, then two large negatives overflow.
    q_ops[0] = ops5(-1, -2, 3, 0, 0); q_acc[0] = 0; q_clr[0] = 1;
    q_ops[1] = ops5(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    q_acc[1] = 0; q_clr[1] = 1;
    q_ops[2] = q_ops[1]; q_acc[2] = 1; q_clr[2] = 0;
    runSeq(3);
    checkOutput("s35_count", 64'(r_n[2]), 3);
    checkOutput("s35_mixed_data", r_data[2][0], 64'd0);
    checkOutput("s35_clr_data", r_data[2][1], 64'h5_8000_0000);
    checkOutput("s35_clr_ovf", 64'(r_ovf[2][1]), 0);
    checkOutput("s35_acc_data", r_data[2][2], 64'h3_0000_0000);
    checkOutput("s35_acc_ovf", 64'(r_ovf[2][2]), 1);

    // Reset while three accumulate beats are in flight: none may emerge.
    out_ready = 1'b1;
    any_valid = 0;
    @(negedge clk);
    applyStimulus(ops5(9, 9, 9, 9, 9), 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(ops5(8, 8, 8, 8, 8), 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(ops5(7, 7, 7, 7, 7), 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("rst_in_ready", 64'(ir64), 1);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    for (int cyc = 0; cyc < 8; cyc++) begin
      #1;
      any_valid |= ov64 | ov35 | ovs;
      @(negedge clk);
    end
    #1;
    checkOutput("rst_no_valid", 64'(any_valid), 0);
    checkOutput("rst_out_data", d64, 0);
    checkOutput("rst_out_ovf", 64'(f64), 0);

    q_ops[0] = ops5(1, 2, 3, 4, 5); q_acc[0] = 1; q_clr[0] = 0;
    runSeq(1);
    checkOutput("post_rst_count", 64'(r_n[0]), 1);
    checkOutput("post_rst_data", r_data[0][0], 64'd15);
    checkOutput("post_rst_data35", r_data[1][0], 64'd15);
    checkOutput("post_rst_data_s", r_data[2][0], 64'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_sum_tree.md
Name: pipelined_sum_tree

Overview:
Parametrised, pipelined multi-operand adder. It reduces NUM_OPS operands of IN_W bits to one OUT_W result through a registered binary adder tree. It adds valid/ready flow control, signed/unsigned extension, and an in-band accumulate mode with overflow reporting. This block is the generalised successor of the team's fixed 5x32-bit registered summer, used as a timing-closure test vehicle and datapath building block.

Parameters:
NUM_OPS, 5, number of operands per beat (>=1)
IN_W, 32, width of each operand
OUT_W, 64, result/accumulator width; elaboration error if OUT_W < IN_W + $clog2(NUM_OPS)
SIGNED, 0, 1 = operands sign-extended and signed overflow detection; 0 = zero-extended, unsigned carry-out

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
in_data  in  NUM_OPS*IN_W  packed operands, operand k at [k*IN_W +: IN_W]
in_acc  in  1  beat mode: 1 = add tree sum into accumulator, 0 = pass tree sum
in_clr  in  1  beat restarts accumulation (overrides in_acc)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  OUT_W  result / accumulator value
out_ovf  out  1  overflow occurred on this result beat

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high. No asynchronous logic.
- Reset: the cycle after rst=1, all stage valids=0, out_valid=0, out_data=0, out_ovf=0, accumulator=0. in_ready=1 while in reset. In-flight beats are discarded; reset mid-operation yields no output.
- Operands are extended to OUT_W per SIGNED before the first adder level.
- Tree: LEVELS = max(1, $clog2(NUM_OPS)) registered levels. Each level adds pairs; an odd leftover passes through registered, unchanged. in_acc and in_clr travel with the beat in every level.
- Output stage: one further register holds out_data, out_ovf and out_valid. Latency from accepted input (in_valid & in_ready) to out_valid = LEVELS+1 cycles (4 for defaults) with no stall.
- Output update on beat arrival:
  - in_clr=1 or in_acc=0: out_data <= tree_sum.
  - Otherwise: out_data <= out_data + tree_sum, modulo 2^OUT_W.
- out_ovf: asserted with the beat when the accumulate add overflows. Unsigned: carry out of OUT_W. Signed: operands share a sign and the result sign differs. out_ovf is always 0 for pass/clear beats and is not sticky.
- Flow control: stall = out_valid & ~out_ready. in_ready = ~stall, combinational. While stall=1, all pipeline registers and the accumulator hold. Bubbles are not compressed.
- Handshake rules: out_data, out_ovf and out_valid stay stable while out_valid=1 and out_ready=0. A beat is never dropped or duplicated. When downstream is ready, one beat per cycle is sustained.
- Simultaneous output accept and new arrival: the arrival loads the output stage in the same cycle, so there is no bubble.
- NUM_OPS=1: one pass-through level, latency 2.

Decomposition:
- Package sum_tree_pkg:
  - function sum_levels(n), returning max(1,clog2(n));
  - function ext_operand for sign/zero extension;
  - typedef beat_ctrl_t as a struct {acc, clr, valid}.
- Sub-module sum_tree_level: one registered pairwise-reduction level, parametrised by input count and width, with stall/enable and sideband pass-through. The top instantiates it in a generate loop LEVELS times and adds the output/accumulator stage.

Test Plan:
- Defaults, SIGNED=0, out_ready=1, all five operands 32'hFFFF_FFFF, in_acc=0 -> out_valid 4 cycles after accept, out_data=64'h4_FFFF_FFFB, out_ovf=0.
- Operands 1,2,3,4,5 with in_clr=1, then the same beat three times with in_acc=1 -> out_data sequence 15, 30, 45, 60 on consecutive cycles.
- Stream 8 beats, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 during the stall, outputs held stable, all 8 sums appear in order with no loss or duplication.
- OUT_W=35, SIGNED=0, clear with five 32'hFFFF_FFFF, then accumulate the same -> second result 35'h1_FFFF_FFF6, out_ovf=1.
- SIGNED=1, operands -1,-2,3,0,0 -> out_data=0. SIGNED=1, OUT_W=35, clear with five 32'h8000_0000, then accumulate the same -> out_ovf=1.
- Accept 3 beats, assert rst for 1 cycle at the 2nd cycle -> no out_valid from those beats, out_data=0. Next beat after reset with in_acc=1 and operands 1..5 -> out_data=15, because the accumulator is zero after reset.
